game_status_tx: RTL and testbench



---
 rtl/game_pkg.sv | 23 ++
 rtl/bcd_score_counter.sv | 41 ++++
 rtl/game_status_tx.sv | 179 +++++++++++++++++
 tb/tb_game_status_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game status uplink: game states, TX FSM
// states, packet lengths and the byte index type.
package game_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    END   = 2'd1,
    GAME  = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } tx_fsm_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam int         PKT_LEN_CS       = 7;
  localparam int         PKT_LEN          = 6;

  typedef logic [2:0] byte_idx_t;

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score counter with synchronous clear and saturation at 9999.
module bcd_score_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_inc,
  output logic [15:0] o_score
);

  logic [15:0] r_score;
  logic [15:0] w_next;

  always_comb begin
    logic carry;
    w_next = r_score;
    carry  = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r_score[4*d +: 4] == 4'd9) begin
          w_next[4*d +: 4] = 4'd0;
        end else begin
          w_next[4*d +: 4] = r_score[4*d +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    // A ripple out of the thousands digit would wrap to 0000; pin at 9999.
    if (r_score == 16'h9999) w_next = r_score;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_score <= 16'h0000;
    end else if (i_inc) begin
      r_score <= w_next;
    end
  end

  assign o_score = r_score;

endmodule

// File: rtl/game_status_tx.sv
// Game status uplink: frames state, bird height and BCD score into byte packets
// over a valid/ready handshake. Define GAME_STATUS_CHECKSUM_EN for a 7th XOR byte.
module game_status_tx
  import game_pkg::*;
#(
  parameter int         REPORT_DIV = 4,
  parameter logic [11:0] BIRD_X    = 12'd216,
  parameter logic [7:0]  HDR_BYTE  = HDR_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs_in,
  input  logic [1:0]  state,
  input  logic [11:0] bird_loc_y,
  input  logic [11:0] tube1_x,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic [15:0] score,
  output logic        busy
);

`ifdef GAME_STATUS_CHECKSUM_EN
  localparam byte_idx_t LAST_IDX = byte_idx_t'(PKT_LEN_CS - 1);
`else
  localparam byte_idx_t LAST_IDX = byte_idx_t'(PKT_LEN - 1);
`endif

  logic [1:0]  r_state;
  logic        r_vs;
  logic [11:0] r_tube_x;
  logic [7:0]  r_frame_cnt;
  logic        r_chg_pend;
  logic        r_per_pend;
  tx_fsm_t     r_fsm;
  tx_fsm_t     w_fsm_next;
  logic [1:0]  r_pkt_state;
  logic [11:0] r_pkt_y;
  logic [15:0] r_pkt_score;
  byte_idx_t   r_idx;
  byte_idx_t   w_idx_next;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [7:0]  w_next_byte;
  logic        w_frame;
  logic        w_chg;
  logic        w_per;
  logic        w_inc;
  logic        w_clear;
  logic        w_accept;
  logic        w_in_game;
  logic [15:0] w_score;
`ifdef GAME_STATUS_CHECKSUM_EN
  logic [7:0]  r_cs;
  logic [7:0]  w_cs_next;
`endif

  // Input history registers track the inputs even through reset so that
  // leaving reset never looks like a state change or frame edge.
  always_ff @(posedge clk) begin
    r_state  <= state;
    r_vs     <= vs_in;
    r_tube_x <= tube1_x;
  end

  assign w_in_game = (state == GAME);
  assign w_frame   = r_vs && !vs_in;
  assign w_chg     = (state != r_state);
  assign w_per     = w_in_game && w_frame && (r_frame_cnt == 8'(REPORT_DIV - 1));
  assign w_clear   = (state == START);
  assign w_inc     = w_in_game && (r_tube_x >= BIRD_X) && (tube1_x < BIRD_X);
  assign w_accept  = r_tx_valid && tx_data_ready;

  bcd_score_counter u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_score (w_score)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !w_in_game) begin
      r_frame_cnt <= 8'd0;
    end else if (w_frame) begin
      r_frame_cnt <= w_per ? 8'd0 : r_frame_cnt + 8'd1;
    end
  end

  // Flags are consumed when IDLE leaves for LOAD; a same-cycle trigger re-arms.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chg_pend <= 1'b0;
      r_per_pend <= 1'b0;
    end else if (r_fsm == IDLE && (r_chg_pend || r_per_pend)) begin
      r_chg_pend <= w_chg;
      r_per_pend <= w_per;
    end else begin
      r_chg_pend <= r_chg_pend || w_chg;
      r_per_pend <= r_per_pend || w_per;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      IDLE:    if (r_chg_pend || r_per_pend) w_fsm_next = LOAD;
      LOAD:    w_fsm_next = SEND;
      SEND:    if (w_accept && r_idx == LAST_IDX) w_fsm_next = IDLE;
      default: w_fsm_next = IDLE;
    endcase
  end

  // r_tx_data always holds byte[r_idx], so the running checksum folds it in
  // directly and the checksum byte is ready the moment byte 5 is accepted.
  always_comb begin
    w_idx_next = r_idx + byte_idx_t'(1);
`ifdef GAME_STATUS_CHECKSUM_EN
    w_cs_next  = (r_idx == byte_idx_t'(0)) ? r_cs : (r_cs ^ r_tx_data);
`endif
    case (w_idx_next)
      3'd1:    w_next_byte = {6'b0, r_pkt_state};
      3'd2:    w_next_byte = {4'b0, r_pkt_y[11:8]};
      3'd3:    w_next_byte = r_pkt_y[7:0];
      3'd4:    w_next_byte = r_pkt_score[15:8];
      3'd5:    w_next_byte = r_pkt_score[7:0];
`ifdef GAME_STATUS_CHECKSUM_EN
      default: w_next_byte = w_cs_next;
`else
      default: w_next_byte = 8'h00;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_fsm == LOAD) begin
      r_pkt_state <= state;
      r_pkt_y     <= bird_loc_y;
      r_pkt_score <= w_score;
    end
  end

  // LOAD -> SEND boundary presents the header; SEND advances on each accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_idx      <= byte_idx_t'(0);
`ifdef GAME_STATUS_CHECKSUM_EN
      r_cs       <= 8'h00;
`endif
    end else if (r_fsm == LOAD) begin
      r_tx_data  <= HDR_BYTE;
      r_tx_valid <= 1'b1;
      r_idx      <= byte_idx_t'(0);
`ifdef GAME_STATUS_CHECKSUM_EN
      r_cs       <= 8'h00;
`endif
    end else if (r_fsm == SEND && w_accept) begin
      r_idx <= w_idx_next;
`ifdef GAME_STATUS_CHECKSUM_EN
      r_cs  <= w_cs_next;
`endif
      if (r_idx == LAST_IDX) r_tx_valid <= 1'b0;
      else                   r_tx_data  <= w_next_byte;
    end
  end

  assign tx_data       = r_tx_data;
  assign tx_data_valid = r_tx_valid;
  assign score         = w_score;
  assign busy          = (r_fsm != IDLE);

endmodule

// File: tb/tb_game_status_tx.sv
// Directed bench for game_status_tx: reset, packet framing, backpressure,
// BCD scoring and saturation, periodic/queued reports and reset mid-packet.
module tb_game_status_tx;

`ifdef GAME_STATUS_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_in = 1'b1;
  logic [1:0]  state = 2'd0;
  logic [11:0] bird_loc_y = 12'd240;
  logic [11:0] tube1_x = 12'd300;
  logic        tx_data_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic [15:0] score;
  logic        busy;

  game_status_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vs_in         (vs_in),
    .state         (state),
    .bird_loc_y    (bird_loc_y),
    .tube1_x       (tube1_x),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .score         (score),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Passive packet monitor, sampled on the falling edge.
  logic       busy_q = 1'b0;
  int         pkt_cnt = 0;
  int         bidx = 0;
  int         valid_cnt = 0;
  logic [7:0] last_st = 8'h00;

  always @(negedge clk) begin
    if (busy && !busy_q) begin
      pkt_cnt++;
      bidx = 0;
    end
    busy_q = busy;
    if (tx_data_valid) valid_cnt++;
    if (tx_data_valid && tx_data_ready) begin
      if (bidx == 1) last_st = tx_data;
      bidx++;
    end
  end

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic exp_pkt(input logic [1:0] st, input logic [11:0] y, input logic [15:0] sc,
                         output logic [7:0] p [0:6]);
    p[0] = 8'hA5;
    p[1] = {6'b0, st};
    p[2] = {4'b0, y[11:8]};
    p[3] = y[7:0];
    p[4] = sc[15:8];
    p[5] = sc[7:0];
    p[6] = p[1] ^ p[2] ^ p[3] ^ p[4] ^ p[5];
  endtask

  task automatic get_packet(input int stall_at, input int stall_len,
                            output logic [7:0] pkt [0:6], output int n);
    int guard;
    int stalls;
    logic [7:0] held;
    n = 0; stalls = 0; guard = 0; held = 8'h00;
    for (int i = 0; i < 7; i++) pkt[i] = 8'h00;
    while (!tx_data_valid && guard < 20) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    chk("pkt_start_valid", {31'b0, tx_data_valid}, 32'd1);
    chk("pkt_busy", {31'b0, busy}, 32'd1);
    if (!tx_data_valid) return;
    guard = 0;
    while (n < NB && guard < 60) begin
      if (n == stall_at && stalls < stall_len) begin
        tx_data_ready = 1'b0;
        if (stalls == 0) held = tx_data;
        else begin
          chk("bp_data_hold", {24'b0, tx_data}, {24'b0, held});
          chk("bp_valid_hold", {31'b0, tx_data_valid}, 32'd1);
        end
        stalls++;
      end else begin
        tx_data_ready = 1'b1;
        if (tx_data_valid) begin
          pkt[n] = tx_data;
          n++;
        end
      end
      @(posedge clk); @(negedge clk); guard++;
    end
    tx_data_ready = 1'b1;
  endtask

  task automatic send_and_check(input string tag, input logic [1:0] st, input logic [15:0] sc,
                                input int stall_at, input int stall_len);
    logic [7:0] got [0:6];
    logic [7:0] exp [0:6];
    int n;
    get_packet(stall_at, stall_len, got, n);
    exp_pkt(st, bird_loc_y, sc, exp);
    chk({tag, "_len"}, n, NB);
    for (int i = 0; i < NB; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'b0, got[i]}, {24'b0, exp[i]});
    chk({tag, "_valid_drop"}, {31'b0, tx_data_valid}, 32'd0);
  endtask

  task automatic step_tube(input logic [11:0] x);
    tube1_x = x;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic frame();
    vs_in = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    vs_in = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
  endtask

  typedef struct {
    logic [11:0] tube;
    logic [15:0] exp_score;
  } score_vec_t;

  score_vec_t vecs[$];

  initial begin
    int sc_n;
    int base;
    int guard;
    int vc;

    // Scoring vectors: the 216->215 step is the first pass; then pairs of passes.
    vecs.push_back('{12'd217, 16'h0000});
    vecs.push_back('{12'd216, 16'h0000});
    vecs.push_back('{12'd215, 16'h0001});
    vecs.push_back('{12'd215, 16'h0001});
    vecs.push_back('{12'd300, 16'h0001});
    vecs.push_back('{12'd214, 16'h0002});
    for (int k = 3; k <= 17; k++) begin
      vecs.push_back('{12'd300, to_bcd(k - 1)});
      vecs.push_back('{12'd200, to_bcd(k)});
    end

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, tx_data_valid}, 32'd0);
    chk("rst_data", {24'b0, tx_data}, 32'd0);
    chk("rst_score", {16'b0, score}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    chk("idle_no_valid", {31'b0, tx_data_valid}, 32'd0);

    // State change START -> GAME
    state = 2'd2;
    send_and_check("chg_game", 2'd2, 16'h0000, -1, 0);

    // Backpressure on byte 2, then back to GAME
    state = 2'd1;
    send_and_check("bp_end", 2'd1, 16'h0000, 2, 5);
    state = 2'd2;
    send_and_check("regame", 2'd2, 16'h0000, -1, 0);

    // Scoring table
    foreach (vecs[i]) begin
      step_tube(vecs[i].tube);
      chk($sformatf("score_vec%0d", i), {16'b0, score}, {16'b0, vecs[i].exp_score});
    end
    sc_n = 17;

    // END holds the score
    state = 2'd1;
    send_and_check("end_snap", 2'd1, to_bcd(17), -1, 0);
    step_tube(12'd300);
    step_tube(12'd200);
    chk("end_hold", {16'b0, score}, {16'b0, to_bcd(17)});
    state = 2'd2;
    send_and_check("regame2", 2'd2, to_bcd(17), -1, 0);

    // Saturation
    while (sc_n < 9999) begin
      step_tube(12'd300);
      step_tube(12'd200);
      sc_n++;
    end
    chk("sat_reach", {16'b0, score}, 32'h9999);
    step_tube(12'd300);
    step_tube(12'd200);
    chk("sat_hold", {16'b0, score}, 32'h9999);

    // START clears
    state = 2'd0;
    send_and_check("start_clr", 2'd0, 16'h0000, -1, 0);
    chk("start_score", {16'b0, score}, 32'd0);

    // Periodic reports: 12 frames -> 3 packets
    state = 2'd2;
    send_and_check("per_enter", 2'd2, 16'h0000, -1, 0);
    base = pkt_cnt;
    repeat (12) frame();
    repeat (20) begin @(posedge clk); @(negedge clk); end
    chk("per_count", pkt_cnt - base, 3);

    // Change during periodic packet 2 is queued as a 4th (here 3rd) packet
    base = pkt_cnt;
    repeat (8) frame();
    guard = 0;
    while (!((pkt_cnt - base) == 2 && busy) && guard < 40) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    chk("per2_busy", {31'b0, busy}, 32'd1);
    state = 2'd1;
    guard = 0;
    while (!((pkt_cnt - base) == 3 && !busy) && guard < 60) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    chk("queued_count", pkt_cnt - base, 3);
    chk("queued_state", {24'b0, last_st}, 32'h01);
    repeat (20) begin @(posedge clk); @(negedge clk); end
    chk("queued_no_extra", pkt_cnt - base, 3);

    // Reset in the middle of a packet
    state = 2'd2;
    guard = 0;
    while (!(busy && bidx >= 3) && guard < 30) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    chk("mid_reached", {31'b0, busy}, 32'd1);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_valid", {31'b0, tx_data_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    vc = valid_cnt;
    repeat (20) begin @(posedge clk); @(negedge clk); end
    chk("post_rst_silent", valid_cnt - vc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
